inst_queue_n: RTL and testbench

//   Parametrised N-entry instruction queue between fetch and decode; successor to the fixed-depth queue.

---
 rtl/inst_queue_n_pkg.sv | 14 +
 rtl/inst_queue_n_if.sv | 32 +++
 rtl/inst_queue_n_storage_ram.sv | 38 +++
 rtl/inst_queue_n.sv | 119 +++++++++++
 tb/tb_inst_queue_n.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_queue_n_pkg.sv
// Shared constants for the fetch/decode instruction queue.
// WORD/ADDR are the instruction and pc widths; Q_DEPTH is the depth of the top-level instance.
package inst_queue_n_pkg;

  localparam int unsigned WORD    = 32;
  localparam int unsigned ADDR    = 32;
  localparam int unsigned Q_DEPTH = 4;

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/inst_queue_n_if.sv
// Fetch/decode handshake bundle for inst_queue_n.
// slave is the queue side, master is the fetch/decode/execute environment side.
interface inst_queue_n_if
  import inst_queue_n_pkg::*;
#(
  parameter int unsigned DEPTH = Q_DEPTH
) ();

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            v_i;
  logic            stall_o;
  logic [WORD-1:0] inst_i;
  logic [ADDR-1:0] pc_i;
  logic            v_o;
  logic            stall_i;
  logic [WORD-1:0] inst_o;
  logic [ADDR-1:0] pc_o;
  logic            branch_i;
  logic [CW-1:0]   count_o;

  modport slave (
    input  v_i, inst_i, pc_i, stall_i, branch_i,
    output stall_o, v_o, inst_o, pc_o, count_o
  );

  modport master (
    output v_i, inst_i, pc_i, stall_i, branch_i,
    input  stall_o, v_o, inst_o, pc_o, count_o
  );

endinterface

// File: rtl/inst_queue_n_storage_ram.sv
// queue_storage_ram: DEPTH x WIDTH register file with one synchronous write port,
// one asynchronous read port and a synchronous clear on reset.
module queue_storage_ram #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next-state of the array: at most one entry replaced per cycle.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Array state register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_queue_n.sv
// inst_queue_n: DEPTH-entry {inst, pc} queue between fetch and decode, flushed by a taken branch.
// Optional feature macro QUEUE_BYPASS_EN: when the queue is empty, a valid fetch word is
// forwarded combinationally to decode and is only written if decode stalls.
module inst_queue_n
  import inst_queue_n_pkg::*;
#(
  parameter int unsigned DEPTH = Q_DEPTH
) (
  input logic           clk,
  input logic           reset,
  inst_queue_n_if.slave q
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = WORD + ADDR;

  if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("inst_queue_n: DEPTH must be a power of two and at least 2");
  end

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          full;
  logic          not_empty;
  logic          v_o;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          rd_adv;
  logic [EW-1:0] rdata;
  logic [EW-1:0] head;

  // Backpressure depends on registered occupancy only.
  assign full      = (count_q == CW'(DEPTH));
  assign not_empty = (count_q != '0);

  assign push = q.v_i & ~full & ~q.branch_i;
  assign pop  = v_o & ~q.stall_i & ~q.branch_i;

`ifdef QUEUE_BYPASS_EN
  logic byp;
  // Reset is included so a held reset never shows a forwarded word.
  assign byp    = ~not_empty & q.v_i & ~q.branch_i & ~reset;
  // A bypassed word taken by decode is never stored; a stalled one is stored normally.
  assign wr_en  = push & ~(byp & ~q.stall_i);
  assign rd_adv = pop & ~byp;
`else
  assign wr_en  = push;
  assign rd_adv = pop;
`endif

  // Pointer and occupancy next-state; a branch discards this cycle's push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (q.branch_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_adv) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(wr_en) - CW'(rd_adv);
    end
  end

  // Control state register; reset takes priority over branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  queue_storage_ram #(
    .DEPTH(DEPTH),
    .WIDTH(EW)
  ) u_storage (
    .clk  (clk),
    .reset(reset),
    .we   (wr_en),
    .waddr(wr_ptr_q),
    .wdata({q.inst_i, q.pc_i}),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );

  // Decode-side outputs: head of storage, or the live fetch word when bypassing.
  always_comb begin
    v_o  = not_empty;
    head = rdata;
`ifdef QUEUE_BYPASS_EN
    if (byp) begin
      v_o  = 1'b1;
      head = {q.inst_i, q.pc_i};
    end
`endif
  end

  assign q.v_o     = v_o;
  assign q.inst_o  = head[EW-1:ADDR];
  assign q.pc_o    = head[ADDR-1:0];
  assign q.stall_o = full;
  assign q.count_o = count_q;

endmodule

// File: tb/tb_inst_queue_n.sv
// Self-checking bench for inst_queue_n: directed scenarios plus a randomized run,
// all compared against a queue-based reference model.
module tb_inst_queue_n;
  import inst_queue_n_pkg::*;

  localparam int unsigned D  = Q_DEPTH;
  localparam int unsigned CW = $clog2(D) + 1;

  typedef struct packed {
    logic [WORD-1:0] inst;
    logic [ADDR-1:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic reset;

  inst_queue_n_if #(.DEPTH(D)) qif ();

  inst_queue_n #(.DEPTH(D)) dut (
    .clk  (clk),
    .reset(reset),
    .q    (qif)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  ent_t m_q[$];

  // Reference model: the queue contents as an ordered list of entries.
  function automatic bit m_byp();
`ifdef QUEUE_BYPASS_EN
    return (m_q.size() == 0) && (qif.v_i === 1'b1) && (qif.branch_i === 1'b0) && (reset === 1'b0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_v();
    return (m_q.size() != 0) || m_byp();
  endfunction

  function automatic ent_t m_head();
    if (m_byp()) return {qif.inst_i, qif.pc_i};
    return m_q[0];
  endfunction

  function automatic void model_step();
    ent_t cur;
    bit   full;
    cur  = {qif.inst_i, qif.pc_i};
    full = (m_q.size() == D);
    if (reset) begin
      m_q.delete();
    end else if (qif.branch_i) begin
      m_q.delete();
    end else if (m_byp()) begin
      if (qif.stall_i) m_q.push_back(cur);
    end else begin
      if (m_q.size() != 0 && !qif.stall_i) void'(m_q.pop_front());
      if (qif.v_i && !full) m_q.push_back(cur);
    end
  endfunction

  // Advance the model with the current inputs and move to just after the next edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [WORD-1:0] inst, input logic [ADDR-1:0] pc,
                       input bit st, input bit br);
    qif.v_i      = v;
    qif.inst_i   = inst;
    qif.pc_i     = pc;
    qif.stall_i  = st;
    qif.branch_i = br;
  endtask

  task automatic flush();
    drive(0, '0, '0, 0, 1);
    #4;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 32'h1234, 32'h55, 0, 0);
    tick();
    #4;
    checks++; if (qif.v_o !== 1'b0) begin failures++; $display("FAIL reset_v_o got=%0b want=0", qif.v_o); end
    checks++; if (qif.stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall_o got=%0b want=0", qif.stall_o); end
    checks++; if (qif.count_o !== CW'(0)) begin failures++; $display("FAIL reset_count got=%0d want=0", qif.count_o); end
    checks++; if (qif.inst_o !== '0) begin failures++; $display("FAIL reset_inst got=%h want=0", qif.inst_o); end
    checks++; if (qif.pc_o !== '0) begin failures++; $display("FAIL reset_pc got=%h want=0", qif.pc_o); end
    tick();
    reset = 1'b0;
    drive(1, 32'hA0, 32'h10, 1, 0);
    #4;
    tick();
    drive(0, '0, '0, 1, 0);
    #4;
    checks++; if (qif.v_o !== 1'b1) begin failures++; $display("FAIL first_push_v got=%0b want=1", qif.v_o); end
    checks++; if (qif.inst_o !== 32'hA0) begin failures++; $display("FAIL first_push_inst got=%h want=a0", qif.inst_o); end
    checks++; if (qif.pc_o !== 32'h10) begin failures++; $display("FAIL first_push_pc got=%h want=10", qif.pc_o); end
    tick();
    flush();
  endtask

  task automatic test_fill_drain();
    int  w;
    int  exp;
    bit  acc;
    bit  v;
    w = 1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      drive(1, w, w * 4, 1, 0);
      #4;
      if (cyc == 4) begin
        checks++; if (qif.count_o !== CW'(4)) begin failures++; $display("FAIL fill_count got=%0d want=4", qif.count_o); end
        checks++; if (qif.stall_o !== 1'b1) begin failures++; $display("FAIL fill_stall got=%0b want=1", qif.stall_o); end
      end
      acc = (m_q.size() < D);
      tick();
      if (acc) w++;
    end
    exp = 1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      v = (w <= 5);
      drive(v, w, w * 4, 0, 0);
      #4;
      if (qif.v_o === 1'b1) begin
        checks++;
        if (qif.inst_o !== exp || qif.pc_o !== exp * 4) begin
          failures++;
          $display("FAIL drain_order got=%h/%h want=%h/%h", qif.inst_o, qif.pc_o, exp, exp * 4);
        end
        exp++;
      end
      acc = v && (m_q.size() < D);
      tick();
      if (acc) w++;
    end
    checks++; if (exp != 6) begin failures++; $display("FAIL drain_total got=%0d want=5", exp - 1); end
  endtask

  task automatic test_stream();
    for (int k = 0; k <= 12; k++) begin
      drive(1, 32'h100 + k, 32'h2000 + 4 * k, 0, 0);
      #4;
      if (k > 0) begin
`ifdef QUEUE_BYPASS_EN
        checks++; if (qif.count_o !== CW'(0)) begin failures++; $display("FAIL stream_count got=%0d want=0", qif.count_o); end
        checks++; if (qif.inst_o !== 32'h100 + k) begin failures++; $display("FAIL stream_inst got=%h want=%h", qif.inst_o, 32'h100 + k); end
`else
        checks++; if (qif.count_o !== CW'(1)) begin failures++; $display("FAIL stream_count got=%0d want=1", qif.count_o); end
        checks++;
        if (qif.inst_o !== 32'h100 + k - 1 || qif.pc_o !== 32'h2000 + 4 * (k - 1)) begin
          failures++;
          $display("FAIL stream_data got=%h/%h want=%h/%h", qif.inst_o, qif.pc_o, 32'h100 + k - 1, 32'h2000 + 4 * (k - 1));
        end
`endif
      end
      tick();
    end
    flush();
  endtask

  task automatic test_branch();
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h31 + k, 32'h300 + k, 1, 0);
      #4;
      tick();
    end
    drive(0, '0, '0, 1, 0);
    #4;
    checks++; if (qif.count_o !== CW'(3)) begin failures++; $display("FAIL branch_pre_count got=%0d want=3", qif.count_o); end
    drive(1, 32'hEE, 32'h99, 0, 1);
    #4;
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, '0, '0, 0, 0);
      #4;
      checks++; if (qif.v_o !== 1'b0) begin failures++; $display("FAIL branch_v got=%0b want=0", qif.v_o); end
      checks++; if (qif.count_o !== CW'(0)) begin failures++; $display("FAIL branch_count got=%0d want=0", qif.count_o); end
      tick();
    end
    drive(1, 32'h44, 32'h40, 1, 0);
    #4;
    tick();
    drive(0, '0, '0, 1, 0);
    #4;
    checks++; if (qif.inst_o !== 32'h44) begin failures++; $display("FAIL branch_next_inst got=%h want=44", qif.inst_o); end
    tick();
    flush();
  endtask

  task automatic test_full_pop();
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h61 + k, 32'h600 + k, 1, 0);
      #4;
      tick();
    end
    drive(1, 32'h77, 32'h70, 0, 0);
    #4;
    checks++; if (qif.stall_o !== 1'b1) begin failures++; $display("FAIL fullpop_stall got=%0b want=1", qif.stall_o); end
    checks++; if (qif.inst_o !== 32'h61) begin failures++; $display("FAIL fullpop_head got=%h want=61", qif.inst_o); end
    tick();
    #4;
    checks++; if (qif.count_o !== CW'(3)) begin failures++; $display("FAIL fullpop_count got=%0d want=3", qif.count_o); end
    checks++; if (qif.stall_o !== 1'b0) begin failures++; $display("FAIL fullpop_free got=%0b want=0", qif.stall_o); end
    checks++; if (qif.inst_o !== 32'h62) begin failures++; $display("FAIL fullpop_head2 got=%h want=62", qif.inst_o); end
    tick();
    drive(0, '0, '0, 1, 0);
    #4;
    checks++; if (qif.count_o !== CW'(3)) begin failures++; $display("FAIL fullpop_after got=%0d want=3", qif.count_o); end
    checks++; if (qif.inst_o !== 32'h63) begin failures++; $display("FAIL fullpop_head3 got=%h want=63", qif.inst_o); end
    tick();
    flush();
  endtask

`ifdef QUEUE_BYPASS_EN
  task automatic test_bypass();
    drive(1, 32'hBB, 32'hB0, 0, 0);
    #4;
    checks++; if (qif.v_o !== 1'b1) begin failures++; $display("FAIL byp_v got=%0b want=1", qif.v_o); end
    checks++; if (qif.inst_o !== 32'hBB) begin failures++; $display("FAIL byp_inst got=%h want=bb", qif.inst_o); end
    tick();
    drive(0, '0, '0, 0, 0);
    #4;
    checks++; if (qif.count_o !== CW'(0)) begin failures++; $display("FAIL byp_count got=%0d want=0", qif.count_o); end
    drive(1, 32'hBB, 32'hB0, 1, 0);
    #4;
    tick();
    drive(0, '0, '0, 1, 0);
    #4;
    checks++; if (qif.count_o !== CW'(1)) begin failures++; $display("FAIL byp_stall_count got=%0d want=1", qif.count_o); end
    tick();
    flush();
  endtask
`endif

  task automatic test_random();
    ent_t h;
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset = ($urandom_range(63) == 0);
      drive($urandom_range(9) < 7, $urandom, $urandom, $urandom_range(9) < 4, $urandom_range(15) == 0);
      #4;
      checks++;
      if (qif.v_o !== m_v() || qif.stall_o !== (m_q.size() == D) || qif.count_o !== CW'(m_q.size())) begin
        failures++;
        $display("FAIL rand_ctrl cyc=%0d got v=%0b s=%0b c=%0d want v=%0b s=%0b c=%0d", cyc, qif.v_o,
                 qif.stall_o, qif.count_o, m_v(), m_q.size() == D, m_q.size());
      end
      if (m_v()) begin
        h = m_head();
        checks++;
        if (qif.inst_o !== h.inst || qif.pc_o !== h.pc) begin
          failures++;
          $display("FAIL rand_data cyc=%0d got=%h/%h want=%h/%h", cyc, qif.inst_o, qif.pc_o, h.inst, h.pc);
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, '0, '0, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_fill_drain();
    test_stream();
    test_branch();
    test_full_pop();
`ifdef QUEUE_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without completing the run");
    $fatal(1, "timeout");
  end

endmodule
